mac_rgmii_rx_framer: RTL and testbench

// - Next-generation RGMII RX framer in the rx_clk domain, fed by the IDDR capture outputs.
// - Decodes DV/ER from RX_CTL, strips preamble/SFD, and packs the payload into BYTES-wide words.
// - Flags frame errors (RX_ER, runt, oversize, optional FCS) on the final word.
// - Feeds the RX FIFO / CDC stage; the word-packed output relieves downstream timing.

---
 rtl/mac_rgmii_rx_framer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mac_rgmii_rx_framer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rgmii_rx_framer.sv
// RGMII RX framer: decodes RX_CTL, strips preamble/SFD and packs payload bytes into BYTES-wide words.
// FCS checking is built only when MAC_RX_FCS_CHECK_EN is defined.
module mac_rgmii_rx_framer #(
  parameter int unsigned BYTES   = 4,
  parameter int unsigned PRE_MIN = 6,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 16
) (
  input  logic               rx_clk,
  input  logic               rst_n,
  input  logic [3:0]         d_rise,
  input  logic [3:0]         d_fall,
  input  logic               ctl_rise,
  input  logic               ctl_fall,
  output logic               out_vld,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_keep,
  output logic               out_sof,
  output logic               out_eof,
  output logic               out_err,
  output logic [LEN_W-1:0]   frame_len,
  output logic [LEN_W-1:0]   cnt_good,
  output logic [LEN_W-1:0]   cnt_bad
);

  localparam int unsigned LW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DW = 8 * BYTES;

  typedef enum logic [2:0] {StWait, StIdle, StPream, StData, StDrop} state_e;

  logic [7:0] rx_byte;
  logic       dv;
  logic       er;

  assign rx_byte = {d_fall, d_rise};
  assign dv      = ctl_rise;
  assign er      = ctl_rise ^ ctl_fall;

  state_e           state_q, state_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    stg_q, stg_d;
  logic             stg_vld_q, stg_vld_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             oerr_q, oerr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [BYTES-1:0] keep_q, keep_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic [LEN_W-1:0] good_q, bad_q;
  logic             good_inc, bad_inc;
  logic             crc_bad;
  logic             frame_bad;
  logic [BYTES-1:0] part_keep;
  logic             last_vld;
  logic [DW-1:0]    last_data;
  logic [BYTES-1:0] last_keep;

`ifdef MAC_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB8_8320 : 32'h0000_0000);
    end
    return r;
  endfunction

  // Re-seeded throughout the preamble so it is at FFFFFFFF on the first data byte.
  always_comb begin
    crc_d = crc_q;
    if (state_q == StPream) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (state_q == StData && dv) begin
      crc_d = crc_step(crc_q, rx_byte);
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc_bad = (crc_q != 32'hDEBB_20E3);
`else
  assign crc_bad = 1'b0;
`endif

  assign frame_bad = err_q | (len_q < LEN_W'(MIN_LEN)) | crc_bad;

  // Final word of a frame: the partial accumulator if any lanes are used, else the staged word.
  always_comb begin
    part_keep = '0;
    for (int i = 0; i < BYTES; i++) begin
      part_keep[i] = (LW'(i) < lane_q);
    end
    if (lane_q != '0) begin
      last_vld  = 1'b1;
      last_data = acc_q;
      last_keep = part_keep;
    end else begin
      last_vld  = stg_vld_q;
      last_data = stg_q;
      last_keep = '1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    len_d     = len_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    first_d   = first_q;
    err_d     = err_q;
    vld_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    oerr_d    = oerr_q;
    data_d    = data_q;
    keep_d    = keep_q;
    flen_d    = flen_q;
    good_inc  = 1'b0;
    bad_inc   = 1'b0;

    unique case (state_q)
      StWait: begin
        if (!dv) state_d = StIdle;
      end
      StIdle: begin
        if (dv && rx_byte == 8'h55) begin
          pcnt_d  = 3'd1;
          state_d = StPream;
        end
      end
      StPream: begin
        if (dv && rx_byte == 8'h55) begin
          if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        end else if (dv && rx_byte == 8'hD5 && pcnt_q >= 3'(PRE_MIN)) begin
          state_d   = StData;
          len_d     = '0;
          lane_d    = '0;
          acc_d     = '0;
          stg_vld_d = 1'b0;
          first_d   = 1'b1;
          err_d     = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (dv && len_q == LEN_W'(MAX_LEN)) begin
          // Oversize: flush what is pending as a bad eof and discard the rest.
          vld_d     = last_vld;
          data_d    = last_data;
          keep_d    = last_keep;
          sof_d     = first_q;
          eof_d     = 1'b1;
          oerr_d    = 1'b1;
          flen_d    = LEN_W'(MAX_LEN + 1);
          stg_vld_d = 1'b0;
          bad_inc   = 1'b1;
          state_d   = StDrop;
        end else if (dv) begin
          if (stg_vld_q) begin
            vld_d     = 1'b1;
            data_d    = stg_q;
            keep_d    = '1;
            sof_d     = first_q;
            first_d   = 1'b0;
            stg_vld_d = 1'b0;
          end
          for (int i = 0; i < BYTES; i++) begin
            if (lane_q == LW'(i)) acc_d[8*i +: 8] = rx_byte;
          end
          if (lane_q == LW'(BYTES - 1)) begin
            stg_d     = acc_d;
            stg_vld_d = 1'b1;
            acc_d     = '0;
            lane_d    = '0;
          end else begin
            lane_d = lane_q + LW'(1);
          end
          len_d = len_q + LEN_W'(1);
          if (er) err_d = 1'b1;
        end else begin
          if (len_q == '0) begin
            bad_inc = 1'b1;
          end else begin
            vld_d    = last_vld;
            data_d   = last_data;
            keep_d   = last_keep;
            sof_d    = first_q;
            eof_d    = 1'b1;
            oerr_d   = frame_bad;
            flen_d   = len_q;
            good_inc = ~frame_bad;
            bad_inc  = frame_bad;
          end
          stg_vld_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StDrop: begin
        if (!dv) state_d = StIdle;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWait;
      pcnt_q    <= '0;
      len_q     <= '0;
      lane_q    <= '0;
      acc_q     <= '0;
      stg_q     <= '0;
      stg_vld_q <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      oerr_q    <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
      flen_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      len_q     <= len_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      first_q   <= first_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      oerr_q    <= oerr_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      flen_q    <= flen_d;
      if (good_inc && good_q != '1) good_q <= good_q + LEN_W'(1);
      if (bad_inc && bad_q != '1)   bad_q  <= bad_q + LEN_W'(1);
    end
  end

  assign out_vld   = vld_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_err   = oerr_q;
  assign frame_len = flen_q;
  assign cnt_good  = good_q;
  assign cnt_bad   = bad_q;

endmodule

// File: tb/tb_mac_rgmii_rx_framer.sv
// Self-checking bench for mac_rgmii_rx_framer: table of frame vectors plus hand-written
// sequences for reset mid-frame, empty frame and oversize.
module tb_mac_rgmii_rx_framer;

  localparam int unsigned BYTES   = 4;
  localparam int unsigned PRE_MIN = 6;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned LEN_W   = 16;
`ifdef MAC_RX_FCS_CHECK_EN
  localparam bit FCS_ERR = 1'b1;
`else
  localparam bit FCS_ERR = 1'b0;
`endif

  logic             rx_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       d_rise = '0;
  logic [3:0]       d_fall = '0;
  logic             ctl_rise = 1'b0;
  logic             ctl_fall = 1'b0;
  logic             out_vld;
  logic [31:0]      out_data;
  logic [3:0]       out_keep;
  logic             out_sof;
  logic             out_eof;
  logic             out_err;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] cnt_good;
  logic [LEN_W-1:0] cnt_bad;

  mac_rgmii_rx_framer #(
    .BYTES  (BYTES),
    .PRE_MIN(PRE_MIN),
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_dut (
    .rx_clk   (rx_clk),
    .rst_n    (rst_n),
    .d_rise   (d_rise),
    .d_fall   (d_fall),
    .ctl_rise (ctl_rise),
    .ctl_fall (ctl_fall),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .out_err  (out_err),
    .frame_len(frame_len),
    .cnt_good (cnt_good),
    .cnt_bad  (cnt_bad)
  );

  always #4 rx_clk = ~rx_clk;

  typedef struct {
    logic [31:0]      data;
    logic [3:0]       keep;
    logic             sof;
    logic             eof;
    logic             err;
    logic [LEN_W-1:0] flen;
  } word_t;

  typedef struct {
    int         npre;
    int         len;
    int         er_pos;
    bit         bad_fcs;
    int         exp_words;
    logic [3:0] exp_keep;
    bit         exp_err;
    int         exp_len;
  } vec_t;

  word_t      mon_q[$];
  logic [7:0] fb[0:1599];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         exp_good = 0;
  int         exp_bad = 0;
  vec_t       vecs[10];

  always @(negedge rx_clk) begin
    if (out_vld) mon_q.push_back('{out_data, out_keep, out_sof, out_eof, out_err, frame_len});
  end

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload bytes followed by a little-endian FCS (when the frame has room for one).
  task automatic build(input int len, input bit bad_fcs);
    logic [31:0] c;
    int          pl;
    c  = 32'hFFFF_FFFF;
    pl = (len >= 4) ? len - 4 : len;
    for (int i = 0; i < pl; i++) begin
      fb[i] = 8'(i * 7 + 3);
      c     = crc_ref(c, fb[i]);
    end
    if (len >= 4) begin
      c = ~c;
      for (int k = 0; k < 4; k++) fb[pl + k] = c[8*k +: 8];
      if (bad_fcs) fb[len - 1] = fb[len - 1] ^ 8'h01;
    end
  endtask

  task automatic drive(input bit dv, input bit er, input logic [7:0] b);
    @(negedge rx_clk);
    d_rise   = b[3:0];
    d_fall   = b[7:4];
    ctl_rise = dv;
    ctl_fall = dv ^ er;
  endtask

  task automatic send(input int npre, input int len, input int er_pos);
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < len; i++) drive(1'b1, (i == er_pos), fb[i]);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_frame(input string tag, input int len, input int exp_words,
                             input logic [3:0] exp_keep, input bit exp_err, input int exp_len);
    int nrx;
    nrx = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
    chk({tag, " words"}, 64'(mon_q.size()), 64'(exp_words));
    for (int i = 0; i < exp_words && i < mon_q.size(); i++) begin
      logic [3:0]  k;
      logic [31:0] ed;
      logic [31:0] mask;
      k = (i == exp_words - 1) ? exp_keep : 4'hF;
      for (int j = 0; j < 4; j++) begin
        mask[8*j +: 8] = {8{k[j]}};
        ed[8*j +: 8]   = (i * 4 + j < nrx) ? fb[i * 4 + j] : 8'h00;
      end
      chk($sformatf("%s data[%0d]", tag, i), 64'(mon_q[i].data & mask), 64'(ed & mask));
      chk($sformatf("%s sof/eof/keep[%0d]", tag, i),
          64'({mon_q[i].sof, mon_q[i].eof, mon_q[i].keep}),
          64'({(i == 0), (i == exp_words - 1), k}));
    end
    if (exp_words > 0) begin
      if (mon_q.size() > 0) begin
        chk({tag, " err"}, 64'(mon_q[mon_q.size() - 1].err), 64'(exp_err));
        chk({tag, " frame_len"}, 64'(mon_q[mon_q.size() - 1].flen), 64'(exp_len));
      end
      if (exp_err) exp_bad++;
      else         exp_good++;
    end
    chk({tag, " cnt_good"}, 64'(cnt_good), 64'(exp_good));
    chk({tag, " cnt_bad"}, 64'(cnt_bad), 64'(exp_bad));
    mon_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           npre len er  bad words keep   err      len
    vecs[0] = '{7, 64, -1, 0, 16, 4'hF, 1'b0,    64};
    vecs[1] = '{7, 65, -1, 0, 17, 4'h1, 1'b0,    65};
    vecs[2] = '{7, 64, 20, 0, 16, 4'hF, 1'b1,    64};
    vecs[3] = '{7, 60, -1, 0, 15, 4'hF, 1'b1,    60};
    vecs[4] = '{7, 64, -1, 1, 16, 4'hF, FCS_ERR, 64};
    vecs[5] = '{5, 64, -1, 0,  0, 4'h0, 1'b0,    0};
    vecs[6] = '{6, 67, -1, 0, 17, 4'h7, 1'b0,    67};
    vecs[7] = '{6,  3, -1, 0,  1, 4'h7, 1'b1,    3};
    vecs[8] = '{7, 70, -1, 0, 18, 4'h3, 1'b0,    70};
    vecs[9] = '{7, 68, 67, 0, 17, 4'hF, 1'b1,    68};

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    chk("reset out_vld", 64'(out_vld), 64'd0);
    chk("reset data/keep", 64'({out_data, out_keep}), 64'd0);
    chk("reset sof/eof/err", 64'({out_sof, out_eof, out_err}), 64'd0);
    chk("reset frame_len", 64'(frame_len), 64'd0);
    chk("reset counters", 64'({cnt_good, cnt_bad}), 64'd0);
    rst_n = 1'b1;

    // Reset pulsed during a preamble; release while the frame keeps going.
    build(64, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h55);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    rst_n = 1'b1;
    send(4, 64, -1);
    check_frame("rst_mid", 64, 0, 4'h0, 1'b0, 0);
    send(7, 64, -1);
    check_frame("after_rst", 64, 16, 4'hF, 1'b0, 64);

    for (int v = 0; v < 10; v++) begin
      build(vecs[v].len, vecs[v].bad_fcs);
      send(vecs[v].npre, vecs[v].len, vecs[v].er_pos);
      check_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_words, vecs[v].exp_keep,
                  vecs[v].exp_err, vecs[v].exp_len);
    end

    // SFD immediately followed by dv low: nothing emitted, counted as bad.
    send(7, 0, -1);
    exp_bad++;
    check_frame("empty", 0, 0, 4'h0, 1'b0, 0);

    // 1600-byte frame truncated at 1518 bytes, then a normal frame.
    build(1600, 1'b0);
    send(7, 1600, -1);
    check_frame("oversize", 1600, 380, 4'h3, 1'b1, 1519);
    build(64, 1'b0);
    send(7, 64, -1);
    check_frame("post_oversize", 64, 16, 4'hF, 1'b0, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
